// File: rtl/regfile_sb.sv
// Decode-stage register file with two combinational read ports, WB->ID bypass
// and a per-register busy scoreboard used for hazard detection.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              flush
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic              w_wrOk;
  logic              w_setOk;
  logic [IDX_W-1:0]  w_wrIdx;
  logic [IDX_W-1:0]  w_setIdx;
  logic [IDX_W-1:0]  w_rdIdx1;
  logic [IDX_W-1:0]  w_rdIdx2;

  // An address is live only if implemented and not the hardwired zero register.
  function automatic logic isValid(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_A) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_wrOk   = we && isValid(wa);
  assign w_setOk  = set_busy && isValid(set_addr);
  assign w_wrIdx  = wa[IDX_W-1:0];
  assign w_setIdx = set_addr[IDX_W-1:0];
  assign w_rdIdx1 = ra1[IDX_W-1:0];
  assign w_rdIdx2 = ra2[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wrOk) begin
      r_regs[w_wrIdx] <= wd;
    end
  end

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      if (w_wrOk) begin
        r_busy[w_wrIdx] <= 1'b0;
      end
      if (w_setOk) begin
        r_busy[w_setIdx] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    if (isValid(ra1)) begin
      if ((BYPASS != 0) && we && (wa == ra1)) begin
        rd1 = wd;
      end else begin
        rd1   = r_regs[w_rdIdx1];
        busy1 = r_busy[w_rdIdx1];
      end
    end
  end

  always_comb begin
    rd2   = '0;
    busy2 = 1'b0;
    if (isValid(ra2)) begin
      if ((BYPASS != 0) && we && (wa == ra2)) begin
        rd2 = wd;
      end else begin
        rd2   = r_regs[w_rdIdx2];
        busy2 = r_busy[w_rdIdx2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default, no-bypass and 16-deep instances
// share one stimulus stream so their responses can be contrasted.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        set_busy;
  logic [4:0]  set_addr;
  logic        flush;

  logic [31:0] rd1A, rd2A, rd1B, rd2B, rd1C, rd2C;
  logic        busy1A, busy2A, busy1B, busy2B, busy1C, busy2C;

  int nAsserts = 0;
  int nFails   = 0;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1A), .rd2(rd2A),
    .busy1(busy1A), .busy2(busy2A),
    .set_busy(set_busy), .set_addr(set_addr), .flush(flush)
  );

  regfile_sb #(.BYPASS(0)) u_noByp (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1B), .rd2(rd2B),
    .busy1(busy1B), .busy2(busy2B),
    .set_busy(set_busy), .set_addr(set_addr), .flush(flush)
  );

  regfile_sb #(.DEPTH(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1C), .rd2(rd2C),
    .busy1(busy1C), .busy2(busy2C),
    .set_busy(set_busy), .set_addr(set_addr), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs on the falling edge, leaving outputs settled 1 time unit later.
  task automatic applyStimulus(input logic iWe, input logic [4:0] iWa, input logic [31:0] iWd,
                               input logic iSet, input logic [4:0] iSetAddr, input logic iFlush);
    @(negedge clk);
    we       = iWe;
    wa       = iWa;
    wd       = iWd;
    set_busy = iSet;
    set_addr = iSetAddr;
    flush    = iFlush;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd5; ra2 = 5'd5;
    set_busy = 1'b0; set_addr = '0; flush = 1'b0;
    #1;
    checkOutput("resetRd1", rd1A, 32'h0);
    checkOutput("resetBusy1", {31'b0, busy1A}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset between edges wipes a committed value and busy bit.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
    checkOutput("r5Written", rd1A, 32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("r5BusySet", {31'b0, busy1A}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetRd1", rd1A, 32'h0);
    checkOutput("midResetBusy1", {31'b0, busy1A}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Same-cycle bypass versus registered-only read.
    ra1 = 5'd7; ra2 = 5'd7;
    applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0);
    checkOutput("bypassRd1", rd1A, 32'h12345678);
    checkOutput("bypassRd2", rd2A, 32'h12345678);
    checkOutput("noBypassOld", rd1B, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("committedRd1", rd1A, 32'h12345678);
    checkOutput("noBypassNew", rd1B, 32'h12345678);

    // Register zero ignores writes and busy sets.
    ra1 = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0);
    checkOutput("zeroRdSame", rd1A, 32'h0);
    checkOutput("zeroBusySame", {31'b0, busy1A}, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("zeroRdNext", rd1A, 32'h0);
    checkOutput("zeroBusyNext", {31'b0, busy1A}, 32'h0);

    // Scoreboard set, bypassed clear, and set winning over same-address clear.
    ra1 = 5'd3;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    checkOutput("setNotYet", {31'b0, busy1A}, 32'h0);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0);
    checkOutput("wbBusyBypass", {31'b0, busy1A}, 32'h0);
    checkOutput("wbBusyNoBypass", {31'b0, busy1B}, 32'h1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("clearedBusy", {31'b0, busy1A}, 32'h0);
    checkOutput("clearedBusyNoByp", {31'b0, busy1B}, 32'h0);
    checkOutput("r3Value", rd1A, 32'h33);
    applyStimulus(1'b1, 5'd3, 32'h44, 1'b1, 5'd3, 1'b0);
    checkOutput("setWbSameRd", rd1A, 32'h44);
    checkOutput("setWbSameBusy", {31'b0, busy1A}, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("setWinsBusy", {31'b0, busy1A}, 32'h1);
    checkOutput("setWinsRd", rd1A, 32'h44);

    // Flush clears every busy bit and suppresses a concurrent set.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    ra1 = 5'd2; ra2 = 5'd9;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1);
    checkOutput("preFlushR2", {31'b0, busy1A}, 32'h1);
    checkOutput("preFlushR9", {31'b0, busy2A}, 32'h1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("flushR2", {31'b0, busy1A}, 32'h0);
    checkOutput("flushR9", {31'b0, busy2A}, 32'h0);
    ra1 = 5'd4; ra2 = 5'd6;
    #1;
    checkOutput("flushR4", {31'b0, busy1A}, 32'h0);
    checkOutput("flushR6", {31'b0, busy2A}, 32'h0);
    ra1 = 5'd3;
    #1;
    checkOutput("flushR3", {31'b0, busy1A}, 32'h0);

    // Unimplemented address in the 16-deep instance must not alias into r4.
    ra1 = 5'd20; ra2 = 5'd4;
    applyStimulus(1'b1, 5'd20, 32'hA5A5A5A5, 1'b1, 5'd20, 1'b0);
    checkOutput("d16RdSame", rd1C, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("d16RdNext", rd1C, 32'h0);
    checkOutput("d16NoAlias", rd2C, 32'h0);
    checkOutput("d16Busy", {31'b0, busy1C}, 32'h0);
    checkOutput("d32R20", rd1A, 32'hA5A5A5A5);
    checkOutput("d32R20Busy", {31'b0, busy1A}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
